present_round_datapath: RTL and testbench
=========================================

# present_round_datapath

Iterative PRESENT encryption datapath. It consumes the 64-bit round keys produced by the round-key generator (gen_round_keyz) and applies addRoundKey, sBoxLayer and pLayer to a 64-bit block, one round per accepted key. It sits directly downstream of the key generator and produces the ciphertext for the top level.

## Interface
Parameters:
- ROUNDS, default 32: number of round keys consumed per block (31 full rounds plus the final whitening key).

Ports (reset is asynchronous and active-high):
- clock  in  1  — system clock; all state changes on the rising edge.
- reset  in  1  — asynchronous, active-high; clears all state immediately.
- start  in  1  — begin a block; sampled only in IDLE.
- plaintext  in  64  — input block; captured on an accepted start.
- round_key  in  64  — current round key from the key generator.
- key_valid  in  1  — round_key is valid.
- key_ready  out  1  — datapath accepts round_key this cycle.
- round_idx  out  6  — index (1..ROUNDS) of the next key expected; 0 when idle.
- busy  out  1  — high in RUN.
- done  out  1  — one-cycle pulse; ciphertext is valid.
- ciphertext  out  64  — result register; holds its value until the next done.

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: consuming round keys.
- IDLE → RUN when start=1:
  - state_reg ← plaintext;
  - round counter ← 1.
- RUN:
  - key_ready=1.
  - A beat is key_valid && key_ready.
  - On a beat with counter < ROUNDS: state_reg ← pLayer(sBoxLayer(state_reg ^ round_key)), then counter increments.
  - On a beat with counter = ROUNDS: ciphertext ← state_reg ^ round_key, done ← 1 next cycle, go to IDLE.
- Stall: key_valid=0 in RUN freezes state_reg and the counter. There is no timeout.
- sBoxLayer: 16 parallel 4-bit S-boxes, nibble i = bits [4i+3:4i]. Table: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- pLayer: bit i moves to position (16·i) mod 63 for i < 63; bit 63 stays at 63.
- Inputs outside RUN:
  - key_valid is ignored (key_ready=0).
  - start is ignored while busy.
- start in the same cycle that done is high: accepted, because the FSM is already in IDLE.
- Reset mid-operation: the block is discarded; FSM → IDLE; no done is produced.

## Timing
- Reset values:
  - key_ready = 0, busy = 0, done = 0;
  - round_idx = 0, ciphertext = 0;
  - FSM = IDLE, state_reg = 0.
- Start accepted at edge T0: busy=1 and key_ready=1 from T0 onward.
- With key_valid held high, beats occur at edges T1..T32.
- ciphertext updates at T32. done is high for exactly the cycle after T32; busy and key_ready fall at T32.
- Minimum latency from start to done is ROUNDS+1 cycles. Each stall cycle adds one cycle.
- round_idx is registered and equals the counter value during RUN.
- done is never asserted for two consecutive cycles.

## Structure
- Package present_pkg:
  - SBOX constant array (16×4);
  - PRESENT_ROUNDS = 32;
  - block width 64;
  - pure function player(64-bit) → 64-bit;
  - FSM state enum {IDLE, RUN}.
- Sub-module present_sbox: 4-bit combinational lookup, instantiated 16 times.
- Top: FSM, round counter, state_reg, ciphertext register and done flag. Target size is about 150–250 lines.

## Test plan
- Round keys are driven by a gen_round_keyz instance with key_valid tied high.
  - Key 0, plaintext 0 → ciphertext 5579C1387B228445, done at start+33.
- Key FFFFFFFFFFFFFFFFFFFF, plaintext 0 → E72C46C0F5945049.
- Key 0, plaintext FFFFFFFFFFFFFFFF → A112FFC72F68417B.
- Key all-F, plaintext all-F → 3333DCD3213210D2, with key_valid randomly deasserted 30% of cycles. Required:
  - same result;
  - done delayed by exactly the number of stall cycles;
  - round_idx frozen during stalls.
- Assert start and pulse reset at round 10, then restart with key 0, plaintext 0. Required:
  - no done for the aborted block;
  - all outputs return to their reset values;
  - the next block yields 5579C1387B228445.
- Pulse start during RUN, drive key_valid during IDLE, and assert start in the done cycle. Required:
  - start during RUN and key_valid during IDLE are ignored;
  - the second block begins immediately and both ciphertexts are correct.

Source files
------------

// File: rtl/present_pkg.sv
// present_pkg: shared constants, types and helpers for the PRESENT round datapath.
//   SBOX           - PRESENT 4-bit substitution table, index = input nibble
//   PRESENT_ROUNDS - round keys consumed per block (31 rounds + whitening key)
//   BLOCK_W        - cipher block width
//   player()       - PRESENT bit permutation
//   state_t        - datapath FSM states
package present_pkg;

  localparam int unsigned PRESENT_ROUNDS = 32;
  localparam int unsigned BLOCK_W        = 64;
  localparam int unsigned NIBBLES        = BLOCK_W / 4;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // Bit i goes to (16*i) mod 63; the top bit is a fixed point of the permutation.
  function automatic logic [BLOCK_W-1:0] player(input logic [BLOCK_W-1:0] din);
    logic [BLOCK_W-1:0] dout;
    dout = '0;
    for (int i = 0; i < 63; i++) begin
      dout[(16 * i) % 63] = din[i];
    end
    dout[63] = din[63];
    return dout;
  endfunction

endpackage

// File: rtl/present_sbox.sv
// present_sbox: single 4-bit PRESENT S-box, purely combinational.
//   din  - input nibble
//   dout - substituted nibble
module present_sbox
  import present_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = SBOX[din];

endmodule

// File: rtl/present_round_datapath.sv
// present_round_datapath: iterative PRESENT encryption, one round per accepted key.
//   clock, reset       - rising-edge clock, asynchronous active-high reset
//   start, plaintext   - begin a block (sampled in IDLE) and its input block
//   round_key          - current round key from the key generator
//   key_valid/ready    - handshake; a beat is key_valid && key_ready
//   round_idx          - index of the next key expected (1..ROUNDS), 0 when idle
//   busy               - high while consuming keys
//   done, ciphertext   - one-cycle pulse; ciphertext held until the next done
module present_round_datapath
  import present_pkg::*;
#(
  parameter int unsigned ROUNDS = PRESENT_ROUNDS
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [63:0]   plaintext,
  input  logic [63:0]   round_key,
  input  logic          key_valid,
  output logic          key_ready,
  output logic [5:0]    round_idx,
  output logic          busy,
  output logic          done,
  output logic [63:0]   ciphertext
);

  state_t              fsm;
  logic [BLOCK_W-1:0]  state_reg;
  logic [BLOCK_W-1:0]  mixed;
  logic [BLOCK_W-1:0]  sboxed;
  logic [BLOCK_W-1:0]  permuted;
  logic                beat;

  // addRoundKey; also the ciphertext value on the final (whitening) key
  assign mixed = state_reg ^ round_key;

  // sBoxLayer: 16 parallel S-boxes
  for (genvar g = 0; g < int'(NIBBLES); g++) begin : g_sbox
    present_sbox u_sbox (
      .din  (mixed[4*g +: 4]),
      .dout (sboxed[4*g +: 4])
    );
  end

  assign permuted = player(sboxed);
  assign beat     = key_valid && key_ready;

  // FSM, round counter (exposed directly as round_idx) and result registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm        <= IDLE;
      state_reg  <= '0;
      round_idx  <= '0;
      busy       <= 1'b0;
      key_ready  <= 1'b0;
      done       <= 1'b0;
      ciphertext <= '0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            fsm       <= RUN;
            state_reg <= plaintext;
            round_idx <= 6'd1;
            busy      <= 1'b1;
            key_ready <= 1'b1;
          end
        end
        RUN: begin
          if (beat) begin
            if (round_idx == 6'(ROUNDS)) begin
              ciphertext <= mixed;
              done       <= 1'b1;
              fsm        <= IDLE;
              round_idx  <= '0;
              busy       <= 1'b0;
              key_ready  <= 1'b0;
            end else begin
              state_reg <= permuted;
              round_idx <= round_idx + 6'd1;
            end
          end
        end
        default: begin
          fsm <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_present_round_datapath.sv
// tb_present_round_datapath: directed self-checking bench for present_round_datapath.
// Round keys come from a PRESENT-80 key schedule model inside the bench; expected
// ciphertexts are the published PRESENT-80 test vectors.
module tb_present_round_datapath;

  logic        clock;
  logic        reset;
  logic        start;
  logic [63:0] plaintext;
  logic [63:0] round_key;
  logic        key_valid;
  logic        key_ready;
  logic [5:0]  round_idx;
  logic        busy;
  logic        done;
  logic [63:0] ciphertext;

  int checks;
  int errors;

  logic [63:0] keys [1:32];

  present_round_datapath #(.ROUNDS(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .plaintext  (plaintext),
    .round_key  (round_key),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .round_idx  (round_idx),
    .busy       (busy),
    .done       (done),
    .ciphertext (ciphertext)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] sbox_m(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
      4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
      4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
    endcase
  endfunction

  // PRESENT-80 key schedule: round key r is the top 64 bits of the register
  task automatic gen_keys(input logic [79:0] key);
    logic [79:0] k;
    k = key;
    for (int r = 1; r <= 32; r++) begin
      keys[r] = k[79:16];
      k = {k[18:0], k[79:19]};
      k[79:76] = sbox_m(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(r);
    end
  endtask

  // Run one block. pre_started: start was already driven in the previous done cycle.
  // poke_start: pulse start mid-run. chain: assert start with next_pt in the done cycle.
  task automatic run_block(input logic [79:0] key, input logic [63:0] pt,
                           input logic [63:0] exp, input int stall_pct,
                           input bit pre_started, input bit poke_start,
                           input bit chain, input logic [63:0] next_pt);
    int k;
    int guard;
    int stalls;
    gen_keys(key);
    if (!pre_started) begin
      @(negedge clock);
      start     = 1'b1;
      plaintext = pt;
      key_valid = 1'b0;
    end
    @(posedge clock);
    k = 1;
    guard = 0;
    stalls = 0;
    while (k <= 32 && guard < 400) begin
      @(negedge clock);
      start     = poke_start && (guard == 4);
      plaintext = start ? 64'hDEAD_BEEF_0BAD_F00D : pt;
      check("busy_run", 64'(busy), 64'd1);
      check("key_ready_run", 64'(key_ready), 64'd1);
      check("round_idx", 64'(round_idx), 64'(k));
      check("done_early", 64'(done), 64'd0);
      round_key = keys[k];
      key_valid = ($urandom_range(99) >= 32'(stall_pct));
      if (!key_valid) stalls++;
      @(posedge clock);
      if (key_valid) k++;
      guard++;
    end
    check("rounds_consumed", 64'(k), 64'd33);
    @(negedge clock);
    key_valid = 1'b0;
    start     = 1'b0;
    check("done", 64'(done), 64'd1);
    check("ciphertext", ciphertext, exp);
    check("busy_end", 64'(busy), 64'd0);
    check("key_ready_end", 64'(key_ready), 64'd0);
    check("round_idx_end", 64'(round_idx), 64'd0);
    if (stall_pct > 0) $display("block with %0d stall cycles", stalls);
    if (chain) begin
      start     = 1'b1;
      plaintext = next_pt;
    end else begin
      @(negedge clock);
      check("done_pulse", 64'(done), 64'd0);
      check("ciphertext_hold", ciphertext, exp);
    end
  endtask

  initial begin
    int dones;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    start     = 1'b0;
    plaintext = '0;
    round_key = '0;
    key_valid = 1'b0;
    #1;
    check("rst_key_ready", 64'(key_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_round_idx", 64'(round_idx), 64'd0);
    check("rst_ciphertext", ciphertext, 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // key_valid while idle must be ignored
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      key_valid = 1'b1;
      round_key = 64'h0123_4567_89AB_CDEF;
      check("idle_key_ready", 64'(key_ready), 64'd0);
      check("idle_round_idx", 64'(round_idx), 64'd0);
    end

    // key 0 / pt 0, start poked mid-run, next block started in the done cycle
    run_block(80'h0, 64'h0, 64'h5579C1387B228445, 0, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    run_block(80'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hA112FFC72F68417B, 0, 1'b1, 1'b0, 1'b0, 64'h0);
    run_block({80{1'b1}}, 64'h0, 64'hE72C46C0F5945049, 0, 1'b0, 1'b0, 1'b0, 64'h0);
    run_block({80{1'b1}}, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3333DCD3213210D2, 30, 1'b0, 1'b0, 1'b0, 64'h0);

    // abort at round 10 with reset
    gen_keys(80'h0);
    @(negedge clock);
    start     = 1'b1;
    plaintext = 64'h0;
    @(posedge clock);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      start     = 1'b0;
      key_valid = 1'b1;
      round_key = keys[k];
      @(posedge clock);
    end
    @(negedge clock);
    key_valid = 1'b0;
    check("abort_round_idx", 64'(round_idx), 64'd10);
    reset = 1'b1;
    #1;
    check("abort_key_ready", 64'(key_ready), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_round_idx0", 64'(round_idx), 64'd0);
    check("abort_ciphertext", ciphertext, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      key_valid = 1'b1;
      round_key = keys[(i % 32) + 1];
      if (done) dones++;
    end
    key_valid = 1'b0;
    check("abort_no_done", 64'(dones), 64'd0);
    run_block(80'h0, 64'h0, 64'h5579C1387B228445, 0, 1'b0, 1'b0, 1'b0, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
